// File: rtl/mcu_stripe_reader_if.sv
// Pixel stream from the stripe reader to the DCT stage: one 8-bit pixel per beat
// plus MCU/stripe position flags, valid/ready handshake.
interface mcu_stripe_reader_if;
  logic [7:0] out_pixval;
  logic       out_valid;
  logic       out_ready;
  logic       out_mcu_first;
  logic       out_mcu_last;
  logic       out_stripe_last;

  modport master (
    output out_pixval, out_valid, out_mcu_first, out_mcu_last, out_stripe_last,
    input  out_ready
  );

  modport slave (
    input  out_pixval, out_valid, out_mcu_first, out_mcu_last, out_stripe_last,
    output out_ready
  );
endinterface

// File: rtl/mcu_stripe_reader.sv
// Reads a completed 8-line stripe out of the EBR line buffer as 8x8 MCUs in raster order.
// Optional macro MCU_STRIPE_READER_OVERRUN_DETECT_EN enables the sticky overrun flag.
//
// state | meaning
// IDLE  | waiting for the ingester to finish a buffer half
// READ  | issuing EBR reads, one per cycle while the skid buffer has room
// DRAIN | all reads issued, waiting for the last words to leave
module mcu_stripe_reader #(
  parameter int width_pix = 320,
  parameter int num_ebr   = 5,
  parameter int ebr_size  = 512
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        frontbuffer_select,
  output logic                        rd_buffer_select,
  output logic [$clog2(num_ebr)-1:0]  rd_block_select,
  output logic [$clog2(ebr_size)-1:0] rd_addr,
  output logic                        rd_en,
  input  logic [7:0]                  rd_data,
  mcu_stripe_reader_if.master         pix,
  output logic                        busy,
  output logic                        overrun
);

  localparam int mcus   = width_pix / 8;
  localparam int mcu_w  = (mcus > 1) ? $clog2(mcus) : 1;
  localparam int blk_w  = $clog2(num_ebr);
  localparam int addr_w = $clog2(ebr_size);
  localparam int row_w  = addr_w - 6;

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t state, state_nx;

  logic             fbs_q;
  logic             stripe_evt;
  logic             issue;
  logic             space;
  logic             at_mcu_first;
  logic             at_mcu_last;
  logic             at_stripe_last;
  logic [2:0]       px;
  logic [2:0]       py;
  logic [mcu_w-1:0] mcu_cnt;
  logic [blk_w-1:0] blk_cnt;
  logic [row_w-1:0] row_base;
  logic             buf_sel;

  logic             rd_pend;
  logic [2:0]       pend_meta;
  logic [10:0]      fifo_mem [2];
  logic             fifo_wp;
  logic             fifo_rp;
  logic [1:0]       fifo_cnt;
  logic             fifo_push;
  logic             fifo_pop;
  logic             head_valid;
  logic             beat_valid;
  logic [10:0]      beat;

  // History register also loads during reset so release never looks like an edge.
  always_ff @(posedge clock) begin
    fbs_q <= frontbuffer_select;
  end

  assign stripe_evt = frontbuffer_select ^ fbs_q;

  assign at_mcu_first   = (px == 3'd0) && (py == 3'd0);
  assign at_mcu_last    = (px == 3'd7) && (py == 3'd7);
  assign at_stripe_last = at_mcu_last && (mcu_cnt == mcu_w'(mcus - 1));

  // Count the in-flight word as occupied so a stalled sink never loses returning data.
  assign space = (fifo_cnt == 2'd0) || ((fifo_cnt == 2'd1) && !rd_pend);

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    issue    = 1'b0;
    case (state)
      IDLE: begin
        if (stripe_evt) state_nx = READ;
      end
      READ: begin
        if (space) begin
          issue = 1'b1;
          if (at_stripe_last) state_nx = DRAIN;
        end
      end
      DRAIN: begin
        if (!head_valid && !rd_pend) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset || state == IDLE) begin
      px       <= '0;
      py       <= '0;
      mcu_cnt  <= '0;
      blk_cnt  <= '0;
      row_base <= '0;
    end else if (issue) begin
      px <= px + 3'd1;
      if (px == 3'd7) begin
        py <= py + 3'd1;
        if (py == 3'd7) begin
          mcu_cnt <= (mcu_cnt == mcu_w'(mcus - 1)) ? '0 : mcu_cnt + mcu_w'(1);
          if (blk_cnt == blk_w'(num_ebr - 1)) begin
            blk_cnt  <= '0;
            row_base <= row_base + row_w'(1);
          end else begin
            blk_cnt <= blk_cnt + blk_w'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      buf_sel <= 1'b0;
    end else if (state == IDLE && stripe_evt) begin
      buf_sel <= ~frontbuffer_select;
    end
  end

  assign rd_buffer_select = buf_sel;
  assign rd_block_select  = blk_cnt;
  assign rd_addr          = {row_base, py, px};
  assign rd_en            = issue && !reset;
  assign busy             = (state != IDLE) && !reset;

  // Position flags travel alongside the read so they line up with rd_data.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_pend   <= 1'b0;
      pend_meta <= '0;
    end else begin
      rd_pend   <= issue;
      pend_meta <= {at_mcu_first, at_mcu_last, at_stripe_last};
    end
  end

  assign head_valid = (fifo_cnt != 2'd0);
  assign beat_valid = (head_valid || rd_pend) && !reset;
  assign beat       = head_valid ? fifo_mem[fifo_rp] : {rd_data, pend_meta};
  assign fifo_pop   = head_valid && pix.out_ready;
  assign fifo_push  = rd_pend && (head_valid || !pix.out_ready);

  always_ff @(posedge clock) begin
    if (fifo_push) fifo_mem[fifo_wp] <= {rd_data, pend_meta};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fifo_wp  <= 1'b0;
      fifo_rp  <= 1'b0;
      fifo_cnt <= 2'd0;
    end else begin
      if (fifo_push) fifo_wp <= ~fifo_wp;
      if (fifo_pop)  fifo_rp <= ~fifo_rp;
      if (fifo_push && !fifo_pop) begin
        fifo_cnt <= fifo_cnt + 2'd1;
      end else if (fifo_pop && !fifo_push) begin
        fifo_cnt <= fifo_cnt - 2'd1;
      end
    end
  end

  assign pix.out_valid       = beat_valid;
  assign pix.out_pixval      = beat[10:3];
  assign pix.out_mcu_first   = beat[2] && beat_valid;
  assign pix.out_mcu_last    = beat[1] && beat_valid;
  assign pix.out_stripe_last = beat[0] && beat_valid;

`ifdef MCU_STRIPE_READER_OVERRUN_DETECT_EN
  logic overrun_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      overrun_q <= 1'b0;
    end else if (stripe_evt && state != IDLE) begin
      overrun_q <= 1'b1;
    end
  end

  assign overrun = overrun_q && !reset;
`else
  assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_mcu_stripe_reader.sv
// Directed bench for mcu_stripe_reader: full-stripe sequence against a beat model,
// spot-check table, random backpressure, dropped second event and mid-stripe reset.
module tb_mcu_stripe_reader;
  localparam int NE     = 5;
  localparam int W      = 320;
  localparam int MCUS   = W / 8;
  localparam int NBEATS = MCUS * 64;
  localparam int BUFSZ  = 16384;

`ifdef MCU_STRIPE_READER_OVERRUN_DETECT_EN
  localparam int EXP_OVR = 1;
`else
  localparam int EXP_OVR = 0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       frontbuffer_select = 1'b0;
  logic       rd_buffer_select;
  logic [2:0] rd_block_select;
  logic [8:0] rd_addr;
  logic       rd_en;
  logic [7:0] rd_data = 8'd0;
  logic       busy;
  logic       overrun;

  mcu_stripe_reader_if ifc ();

  mcu_stripe_reader #(.width_pix(W), .num_ebr(NE), .ebr_size(512)) dut (
    .clock             (clock),
    .reset             (reset),
    .frontbuffer_select(frontbuffer_select),
    .rd_buffer_select  (rd_buffer_select),
    .rd_block_select   (rd_block_select),
    .rd_addr           (rd_addr),
    .rd_en             (rd_en),
    .rd_data           (rd_data),
    .pix               (ifc),
    .busy              (busy),
    .overrun           (overrun)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [7:0] ram_val(input int blk, input int addr);
    return 8'(((blk * 16) + (addr >> 6)) ^ (addr & 63));
  endfunction

  always @(posedge clock) begin
    if (rd_en) rd_data <= ram_val(int'(rd_block_select), int'(rd_addr));
  end

  function automatic void exp_beat(input int k, output logic [7:0] p, output logic [2:0] f);
    int m, j, px, py, blk, addr;
    m    = k / 64;
    j    = k % 64;
    px   = j % 8;
    py   = j / 8;
    blk  = m % NE;
    addr = (m / NE) * 64 + py * 8 + px;
    p    = ram_val(blk, addr);
    f    = {j == 0, j == 63, (j == 63) && (m == MCUS - 1)};
  endfunction

  // Beat monitor: records every transfer and checks hold-stability while stalled.
  logic [7:0]  b_pix [BUFSZ];
  logic [2:0]  b_flg [BUFSZ];
  int          b_cyc [BUFSZ];
  int          nbeats = 0;
  int          stall_cnt = 0;
  int          stall_err = 0;
  logic        prev_stall = 1'b0;
  logic [10:0] prev_beat = '0;
  logic        rand_rdy = 1'b0;

  always @(negedge clock) begin
    if (prev_stall && !reset) begin
      stall_cnt <= stall_cnt + 1;
      if (!(ifc.out_valid && ({ifc.out_pixval, ifc.out_mcu_first, ifc.out_mcu_last,
                               ifc.out_stripe_last} == prev_beat)))
        stall_err <= stall_err + 1;
    end
    prev_stall <= ifc.out_valid && !ifc.out_ready && !reset;
    prev_beat  <= {ifc.out_pixval, ifc.out_mcu_first, ifc.out_mcu_last, ifc.out_stripe_last};
    if (ifc.out_valid && ifc.out_ready) begin
      if (nbeats < BUFSZ) begin
        b_pix[nbeats] <= ifc.out_pixval;
        b_flg[nbeats] <= {ifc.out_mcu_first, ifc.out_mcu_last, ifc.out_stripe_last};
        b_cyc[nbeats] <= cyc;
      end
      nbeats <= nbeats + 1;
    end
  end

  always @(posedge clock) begin
    if (rand_rdy) #1 ifc.out_ready = ($urandom_range(0, 99) < 30);
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  int t_ev;

  task automatic start_stripe();
    @(posedge clock);
    #1 frontbuffer_select = ~frontbuffer_select;
    t_ev = cyc;
  endtask

  task automatic wait_beats(input int base, input int n, input int limit, input string tag);
    int c;
    c = 0;
    while ((nbeats - base) < n && c < limit) begin
      @(posedge clock);
      c++;
    end
    check({tag, "_timeout"}, 32'((nbeats - base) >= n), 1);
  endtask

  task automatic compare_stripe(input int base, input string tag);
    int err;
    logic [7:0] p;
    logic [2:0] f;
    err = 0;
    for (int k = 0; k < NBEATS; k++) begin
      exp_beat(k, p, f);
      if (b_pix[base + k] !== p || b_flg[base + k] !== f) err++;
    end
    check({tag, "_beat_count"}, 32'(nbeats - base), NBEATS);
    check({tag, "_seq_errors"}, 32'(err), 0);
  endtask

  typedef struct {
    int         beat;
    logic [7:0] pix;
    logic [2:0] flg;
  } spot_t;

  spot_t spots[10];

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int nb_snap;
    int se0;
    int sc0;

    // {beat, pixel, {mcu_first, mcu_last, stripe_last}}
    spots[0] = '{0,    8'd0,   3'b100};
    spots[1] = '{63,   8'd63,  3'b010};
    spots[2] = '{320,  8'd1,   3'b100};
    spots[3] = '{327,  8'd6,   3'b000};
    spots[4] = '{448,  8'd33,  3'b100};
    spots[5] = '{449,  8'd32,  3'b000};
    spots[6] = '{456,  8'd41,  3'b000};
    spots[7] = '{511,  8'd30,  3'b010};
    spots[8] = '{2496, 8'd71,  3'b100};
    spots[9] = '{2559, 8'd120, 3'b011};

    ifc.out_ready = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_out_valid", 32'(ifc.out_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_rd_en", 32'(rd_en), 0);
    check("rst_overrun", 32'(overrun), 0);
    check("rst_rd_buffer_select", 32'(rd_buffer_select), 0);
    check("rst_rd_block_select", 32'(rd_block_select), 0);
    check("rst_rd_addr", 32'(rd_addr), 0);
    check("rst_flags", 32'({ifc.out_mcu_first, ifc.out_mcu_last, ifc.out_stripe_last}), 0);
    @(posedge clock);
    #1 reset = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("post_rst_idle", 32'(busy), 0);

    // Stripe A: full throughput, fixed latency, complete sequence
    ifc.out_ready = 1'b1;
    base = nbeats;
    start_stripe();
    @(negedge clock);
    check("A_rd_en_T", 32'(rd_en), 0);
    @(negedge clock);
    check("A_rd_en_T1", 32'(rd_en), 1);
    check("A_valid_T1", 32'(ifc.out_valid), 0);
    check("A_busy_T1", 32'(busy), 1);
    check("A_addr_T1", 32'({rd_block_select, rd_addr}), 0);
    @(negedge clock);
    check("A_valid_T2", 32'(ifc.out_valid), 1);
    check("A_first_T2", 32'(ifc.out_mcu_first), 1);
    check("A_rd_buffer_select", 32'(rd_buffer_select), 0);
    wait_beats(base, NBEATS, 4000, "A");
    repeat (10) @(posedge clock);
    @(negedge clock);
    compare_stripe(base, "A");
    check("A_first_beat_cycle", 32'(b_cyc[base] - t_ev), 2);
    check("A_back_to_back", 32'(b_cyc[base + NBEATS - 1] - b_cyc[base]), NBEATS - 1);
    check("A_busy_done", 32'(busy), 0);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("A_spot_pix_%0d", spots[i].beat), 32'(b_pix[base + spots[i].beat]),
            32'(spots[i].pix));
      check($sformatf("A_spot_flg_%0d", spots[i].beat), 32'(b_flg[base + spots[i].beat]),
            32'(spots[i].flg));
    end

    // Stripe B: 30% ready duty, other buffer half
    base = nbeats;
    se0  = stall_err;
    sc0  = stall_cnt;
    start_stripe();
    rand_rdy = 1'b1;
    @(negedge clock);
    @(negedge clock);
    check("B_rd_buffer_select", 32'(rd_buffer_select), 1);
    wait_beats(base, NBEATS, 20000, "B");
    @(posedge clock);
    rand_rdy = 1'b0;
    #2 ifc.out_ready = 1'b1;
    repeat (10) @(posedge clock);
    @(negedge clock);
    compare_stripe(base, "B");
    check("B_stall_stable_errors", 32'(stall_err - se0), 0);
    check("B_stalls_seen", 32'((stall_cnt - sc0) > 0), 1);

    // Stripe C: second event mid-stripe is dropped
    base = nbeats;
    start_stripe();
    wait_beats(base, 1000, 4000, "C1000");
    @(posedge clock);
    #1 frontbuffer_select = ~frontbuffer_select;
    @(negedge clock);
    check("C_busy_after_evt", 32'(busy), 1);
    wait_beats(base, NBEATS, 4000, "C");
    repeat (10) @(posedge clock);
    @(negedge clock);
    compare_stripe(base, "C");
    check("C_overrun", 32'(overrun), EXP_OVR);
    nb_snap = nbeats;
    repeat (20) @(posedge clock);
    @(negedge clock);
    check("C_no_restart_busy", 32'(busy), 0);
    check("C_no_restart_beats", 32'(nbeats - nb_snap), 0);

    // Stripe D: reset pulse at beat 500, input toggled under reset
    base = nbeats;
    start_stripe();
    wait_beats(base, 500, 4000, "D500");
    @(posedge clock);
    #1 reset = 1'b1;
    frontbuffer_select = ~frontbuffer_select;
    @(negedge clock);
    check("D_rst_valid", 32'(ifc.out_valid), 0);
    check("D_rst_rd_en", 32'(rd_en), 0);
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("D_post_valid", 32'(ifc.out_valid), 0);
    check("D_post_busy", 32'(busy), 0);
    check("D_post_overrun", 32'(overrun), 0);
    nb_snap = nbeats;
    repeat (20) @(posedge clock);
    @(negedge clock);
    check("D_no_event_busy", 32'(busy), 0);
    check("D_no_event_beats", 32'(nbeats - nb_snap), 0);
    base = nbeats;
    start_stripe();
    wait_beats(base, NBEATS, 4000, "D");
    repeat (10) @(posedge clock);
    @(negedge clock);
    check("D_restart_first_pix", 32'(b_pix[base]), 0);
    check("D_restart_first_flag", 32'(b_flg[base]), 32'(3'b100));
    compare_stripe(base, "D");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mcu_stripe_reader.md
MCU_STRIPE_READER -- requirements
Module: mcu_stripe_reader

Interface
REQ-001 SHALL have parameter width_pix, default 320, image width in pixels, multiple of 8.
REQ-002 SHALL have parameter num_ebr, default 5, number of EBR blocks per buffer half.
REQ-003 SHALL have parameter ebr_size, default 512, entries per EBR.
REQ-004 SHALL have port clock  input  1  single system clock, all logic on posedge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port frontbuffer_select  input  1  write-half indicator from the pixel ingester.
REQ-007 SHALL have port rd_buffer_select  output  1  buffer half being read.
REQ-008 SHALL have port rd_block_select  output  clog2(num_ebr)  EBR being read.
REQ-009 SHALL have port rd_addr  output  clog2(ebr_size)  EBR read address.
REQ-010 SHALL have port rd_en  output  1  read strobe; RAM returns rd_data exactly 1 cycle later.
REQ-011 SHALL have port rd_data  input  8  EBR read data.
REQ-012 SHALL have ports out_pixval output 8, out_valid output 1, out_ready input 1: pixel stream to the DCT stage.
REQ-013 SHALL have ports out_mcu_first, out_mcu_last, out_stripe_last, outputs, 1 bit each: qualify the current out beat.
REQ-014 SHALL have ports busy output 1 and overrun output 1.

Function
REQ-015 Stripe-ready event: frontbuffer_select differs from its value registered on the previous cycle; the completed half is the new value inverted.
REQ-016 State machine: IDLE -> READ on a stripe-ready event; READ -> DRAIN after the last address is issued; DRAIN -> IDLE when the skid buffer is empty.
REQ-017 READ issues mcus_per_stripe = width_pix/8 MCUs in MCU index order 0..N-1, each read raster-wise (px fastest, then py).
REQ-018 MCU m maps to rd_block_select = m mod num_ebr and rd_addr = {m div num_ebr, py[2:0], px[2:0]}; the implementation uses wrap counters, with no divider.
REQ-019 rd_buffer_select is latched at the stripe-ready event and held until IDLE.
REQ-020 rd_en asserts only in READ when the skid buffer has space for the returning word; no rd_data word is ever dropped.
REQ-021 Latency: with the event in cycle T and out_ready held high, the first rd_en is in cycle T+1 and the first out_valid in cycle T+2; the block then sustains 1 beat/cycle.
REQ-022 Handshake: a beat transfers when out_valid && out_ready; out_pixval and the flags stay stable while out_valid && !out_ready.
REQ-023 out_mcu_first is high on beat 0 of each MCU; out_mcu_last on beat 63; out_stripe_last on beat 63 of MCU N-1.
REQ-024 busy is high in READ and DRAIN.
REQ-025 A stripe-ready event while busy is dropped and does not restart or abort the current stripe (see REQ-030/031).
REQ-026 Counter wrap: px 7->0 advances py; py 7->0 advances the MCU counter; the block counter wraps num_ebr-1->0 and increments the row base.

Reset
REQ-027 While reset is high: state IDLE, all counters 0, skid buffer empty, rd_en 0, out_valid 0, all flags 0, busy 0, overrun 0, rd_buffer_select 0, rd_block_select 0, rd_addr 0.
REQ-028 During reset the frontbuffer_select history register loads the current input, so releasing reset causes no spurious event.
REQ-029 Reset asserted mid-stripe abandons the stripe; any rd_data arriving in the next cycle is discarded.

Configuration
REQ-030 With macro MCU_STRIPE_READER_OVERRUN_DETECT_EN defined, a stripe-ready event while busy sets overrun high; overrun stays high until reset.
REQ-031 Without MCU_STRIPE_READER_OVERRUN_DETECT_EN, overrun is constant 0; the event is still dropped.

Verification
REQ-032 Default parameters, toggle frontbuffer_select 0->1, out_ready=1 -> 2560 beats on consecutive cycles from T+2; rd_buffer_select=0; out_stripe_last on beat 2559.
REQ-033 EBRs preloaded with the value (block*16 + addr[8:6]) xor addr[5:0] -> MCU 7 beats come from block 2, addresses 64..127, in px-then-py order.
REQ-034 Random out_ready at 30% duty -> the beat sequence is identical to REQ-032, no beats lost or duplicated, and data stays stable while stalled.
REQ-035 Second toggle at beat 1000 -> stripe completes with 2560 beats; overrun=1 with the macro defined, 0 without.
REQ-036 Reset pulse at beat 500 -> out_valid=0 the next cycle, busy=0, and no event follows reset release; the next toggle restarts at MCU 0 with out_mcu_first=1.
